// File: rtl/ms6205_bus_ctrl.sv
// MS6205 display bus write controller: round-robin arbitration between a console
// stream and a direct addressed port, strobe sequencing, newline and clear handling.
module ms6205_bus_ctrl #(
  parameter int COLUMNS       = 16,
  parameter int ROWS          = 10,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic       Clock_1us,
  input  logic       Rst_n,
  input  logic       con_vld,
  input  logic [7:0] con_char,
  output logic       con_ack,
  input  logic       dir_vld,
  input  logic [7:0] dir_addr,
  input  logic [7:0] dir_data,
  output logic       dir_ack,
  output logic       dir_err,
  output logic [7:0] address,
  output logic [7:0] data_n,
  output logic       write_addr,
  output logic       write_data,
  output logic [7:0] cursor,
  output logic       busy
);

  localparam int MAX_POS = COLUMNS * ROWS;
  localparam int MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CNT = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [8:0]    MAX_POS9  = 9'(MAX_POS);
  localparam logic [8:0]    COLS9     = 9'(COLUMNS);
  localparam logic [7:0]    LAST_POS  = 8'(MAX_POS - 1);
  localparam logic [7:0]    CH_NL     = 8'h0A;
  localparam logic [7:0]    CH_CLR    = 8'h0C;
  localparam logic [7:0]    CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE, SETUP, ADDR_STB, DATA_STB, HOLD, CLEAR_NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_n_q, data_n_d;
  logic [7:0]    cursor_q, cursor_d;
  logic          clr_q, clr_d;
  logic          last_dir_q, last_dir_d;
  logic          con_ack_q, con_ack_d;
  logic          dir_ack_q, dir_ack_d;
  logic          dir_err_q, dir_err_d;

  logic [8:0] cur9, nl9;
  logic [7:0] nl_pos, inc_pos;
  logic       dir_bad, grant_dir, grant_con;

  // Handshake: a requester raises *_vld with a stable payload and holds it until
  // its *_ack pulse; requests are sampled only in IDLE, one grant per edge.
  assign grant_dir = dir_vld && (!con_vld || !last_dir_q);
  assign grant_con = con_vld && !grant_dir;
  assign dir_bad   = {1'b0, dir_addr} >= MAX_POS9;

  assign cur9    = {1'b0, cursor_q};
  assign nl9     = cur9 - (cur9 % COLS9) + COLS9;
  assign nl_pos  = (nl9 >= MAX_POS9) ? 8'd0 : nl9[7:0];
  assign inc_pos = (cursor_q == LAST_POS) ? 8'd0 : cursor_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CW'(1);
    addr_d     = addr_q;
    data_n_d   = data_n_q;
    cursor_d   = cursor_q;
    clr_d      = clr_q;
    last_dir_d = last_dir_q;
    con_ack_d  = 1'b0;
    dir_ack_d  = 1'b0;
    dir_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = SETUP_LD;
        if (grant_dir) begin
          dir_ack_d  = 1'b1;
          last_dir_d = 1'b1;
          if (dir_bad) begin
            dir_err_d = 1'b1;
          end else begin
            state_d  = SETUP;
            addr_d   = dir_addr;
            data_n_d = ~dir_data;
          end
        end else if (grant_con) begin
          con_ack_d  = 1'b1;
          last_dir_d = 1'b0;
          if (con_char == CH_NL) begin
            cursor_d = nl_pos;
          end else if (con_char == CH_CLR) begin
            state_d  = SETUP;
            clr_d    = 1'b1;
            addr_d   = 8'd0;
            data_n_d = ~CH_SPACE;
          end else begin
            state_d  = SETUP;
            addr_d   = cursor_q;
            data_n_d = ~con_char;
            cursor_d = inc_pos;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ADDR_STB;
          cnt_d   = STROBE_LD;
        end
      end
      ADDR_STB: begin
        if (cnt_q == '0) begin
          state_d = DATA_STB;
          cnt_d   = STROBE_LD;
        end
      end
      DATA_STB: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (clr_q && (addr_q != LAST_POS)) begin
            state_d = CLEAR_NEXT;
          end else begin
            state_d  = IDLE;
            data_n_d = 8'hFF;
            if (clr_q) begin
              clr_d    = 1'b0;
              cursor_d = 8'd0;
            end
          end
        end
      end
      CLEAR_NEXT: begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        addr_d  = addr_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The display bus is clocked on the falling edge of the 1 us clock.
  always_ff @(negedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= 8'd0;
      data_n_q   <= 8'hFF;
      cursor_q   <= 8'd0;
      clr_q      <= 1'b0;
      last_dir_q <= 1'b0;
      con_ack_q  <= 1'b0;
      dir_ack_q  <= 1'b0;
      dir_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_n_q   <= data_n_d;
      cursor_q   <= cursor_d;
      clr_q      <= clr_d;
      last_dir_q <= last_dir_d;
      con_ack_q  <= con_ack_d;
      dir_ack_q  <= dir_ack_d;
      dir_err_q  <= dir_err_d;
    end
  end

  assign con_ack    = con_ack_q;
  assign dir_ack    = dir_ack_q;
  assign dir_err    = dir_err_q;
  assign address    = addr_q;
  assign data_n     = data_n_q;
  assign cursor     = cursor_q;
  assign write_addr = (state_q == ADDR_STB);
  assign write_data = (state_q == DATA_STB);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ms6205_bus_ctrl.sv
// Bench for ms6205_bus_ctrl: directed scenarios plus randomized traffic checked
// against a position/queue model of the display writes.
`timescale 1ns/1ps
module tb_ms6205_bus_ctrl;

  localparam int COLS = 16;
  localparam int MAXP = 160;

  logic       clk;
  logic       rst_n;
  logic       con_vld, dir_vld;
  logic [7:0] con_char, dir_addr, dir_data;
  logic       con_ack, dir_ack, dir_err;
  logic [7:0] address, data_n, cursor;
  logic       write_addr, write_data, busy;

  ms6205_bus_ctrl dut (
    .Clock_1us (clk),
    .Rst_n     (rst_n),
    .con_vld   (con_vld),
    .con_char  (con_char),
    .con_ack   (con_ack),
    .dir_vld   (dir_vld),
    .dir_addr  (dir_addr),
    .dir_data  (dir_data),
    .dir_ack   (dir_ack),
    .dir_err   (dir_err),
    .address   (address),
    .data_n    (data_n),
    .write_addr(write_addr),
    .write_data(write_data),
    .cursor    (cursor),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          vectors;
  int          miscompares;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          m_cursor;
  bit          m_last_dir;
  logic        wa_prev, wd_prev;
  logic [15:0] cap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records {address, character} at each address strobe.
  always @(posedge clk) begin
    if (rst_n) begin
      check("strobe_overlap", {31'd0, write_addr & write_data}, 32'd0);
      if (!busy) check("idle_data_n", {24'd0, data_n}, 32'hFF);
      if (write_addr && !wa_prev) begin
        obs_q.push_back({address, ~data_n});
        cap <= {address, data_n};
      end
      if (write_data && !wd_prev) check("data_phase_bus", {16'd0, address, data_n}, {16'd0, cap});
    end
    wa_prev <= write_addr;
    wd_prev <= write_data;
  end

  // ---------------- model helpers ----------------
  function automatic int next_line(input int pos);
    int p;
    p = (pos / COLS + 1) * COLS;
    return (p >= MAXP) ? 0 : p;
  endfunction

  task automatic check_reset_vals();
    check("rst_address", {24'd0, address}, 32'd0);
    check("rst_data_n", {24'd0, data_n}, 32'hFF);
    check("rst_write_addr", {31'd0, write_addr}, 32'd0);
    check("rst_write_data", {31'd0, write_data}, 32'd0);
    check("rst_acks", {29'd0, con_ack, dir_ack, dir_err}, 32'd0);
    check("rst_cursor", {24'd0, cursor}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic compare_writes(input bit prefix_only);
    if (!prefix_only) check("write_total", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("write_%0d", i), {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Driver: issues n_con console and n_dir direct requests (re-raised after each ack)
  // and checks every grant against the model.
  task automatic drive(input int n_con, input logic [7:0] c, input int n_dir,
                       input logic [7:0] a, input logic [7:0] d);
    int con_left = n_con;
    int dir_left = n_dir;
    int cyc = 0;
    int exp_dir, got_dir;
    bit bad;
    con_char = c;
    dir_addr = a;
    dir_data = d;
    con_vld  = (con_left > 0);
    dir_vld  = (dir_left > 0);
    while ((con_left > 0 || dir_left > 0) && cyc < 6000) begin
      @(posedge clk);
      cyc++;
      if (con_ack || dir_ack) begin
        check("ack_overlap", {31'd0, con_ack & dir_ack}, 32'd0);
        exp_dir = (con_vld && dir_vld) ? (m_last_dir ? 0 : 1) : (dir_vld ? 1 : 0);
        got_dir = dir_ack ? 1 : 0;
        check("grant_order", got_dir, exp_dir);
        check("write_count", obs_q.size(), exp_q.size());
        if (got_dir == 1) begin
          m_last_dir = 1'b1;
          bad = (int'(a) >= MAXP);
          check("dir_err", {31'd0, dir_err}, {31'd0, bad});
          check("busy_dir", {31'd0, busy}, {31'd0, !bad});
          if (!bad) exp_q.push_back({a, d});
          dir_left--;
          dir_vld = (dir_left > 0);
        end else begin
          m_last_dir = 1'b0;
          check("dir_err_con", {31'd0, dir_err}, 32'd0);
          if (c == 8'h0A) begin
            m_cursor = next_line(m_cursor);
            check("busy_nl", {31'd0, busy}, 32'd0);
          end else if (c == 8'h0C) begin
            for (int p = 0; p < MAXP; p++) exp_q.push_back({8'(p), 8'h20});
            m_cursor = 0;
            check("busy_clr", {31'd0, busy}, 32'd1);
          end else begin
            exp_q.push_back({8'(m_cursor), c});
            m_cursor = (m_cursor + 1) % MAXP;
            check("busy_con", {31'd0, busy}, 32'd1);
          end
          if (c != 8'h0C) check("cursor", {24'd0, cursor}, m_cursor);
          con_left--;
          con_vld = (con_left > 0);
        end
      end
    end
    check("ack_timeout", con_left + dir_left, 32'd0);
    con_vld = 1'b0;
    dir_vld = 1'b0;
  endtask

  function automatic logic [7:0] rand_printable();
    return 8'($urandom_range(8'h21, 8'h7E));
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    m_cursor   = 0;
    m_last_dir = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_vals();
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int nc, nd;
    logic [7:0] ch;
    vectors     = 0;
    miscompares = 0;
    m_cursor    = 0;
    m_last_dir  = 1'b0;
    rst_n       = 1'b0;
    con_vld     = 1'b0;
    dir_vld     = 1'b0;
    con_char    = 8'h00;
    dir_addr    = 8'h00;
    dir_data    = 8'h00;
    repeat (3) @(posedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // 'A' at cursor 0: exact strobe timing relative to the ack cycle
    @(posedge clk);
    con_char = 8'h41;
    con_vld  = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!con_ack && n < 20);
    check("a_ack_seen", {31'd0, con_ack}, 32'd1);
    con_vld = 1'b0;
    exp_q.push_back({8'h00, 8'h41});
    m_cursor = 1;
    check("a_cursor", {24'd0, cursor}, 32'd1);
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) @(posedge clk);
      check($sformatf("a_con_ack_%0d", k), {31'd0, con_ack}, (k == 1) ? 32'd1 : 32'd0);
      check($sformatf("a_write_addr_%0d", k), {31'd0, write_addr}, (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
      check($sformatf("a_write_data_%0d", k), {31'd0, write_data}, (k >= 7 && k <= 10) ? 32'd1 : 32'd0);
      check($sformatf("a_busy_%0d", k), {31'd0, busy}, (k <= 12) ? 32'd1 : 32'd0);
      check($sformatf("a_address_%0d", k), {24'd0, address}, 32'd0);
      check($sformatf("a_data_n_%0d", k), {24'd0, data_n}, (k <= 12) ? 32'hBE : 32'hFF);
    end
    compare_writes(1'b0);

    // Both requesters continuously valid: dir, con, dir, con
    drive(2, 8'h42, 2, 8'h50, 8'h31);
    wait_idle();
    compare_writes(1'b0);

    // Cursor wrap at 159 and newline behaviour
    while (m_cursor < 144) drive(1, 8'h0A, 0, 8'h00, 8'h00);
    while (m_cursor != 159) drive(1, rand_printable(), 0, 8'h00, 8'h00);
    drive(1, 8'h5A, 0, 8'h00, 8'h00);
    check("wrap_cursor", {24'd0, cursor}, 32'd0);
    drive(1, 8'h0A, 0, 8'h00, 8'h00);
    drive(1, 8'h0A, 0, 8'h00, 8'h00);
    while (m_cursor != 37) drive(1, rand_printable(), 0, 8'h00, 8'h00);
    wait_idle();
    drive(1, 8'h0A, 0, 8'h00, 8'h00);
    check("nl_37_cursor", {24'd0, cursor}, 32'd48);
    while (m_cursor < 144) drive(1, 8'h0A, 0, 8'h00, 8'h00);
    while (m_cursor != 150) drive(1, rand_printable(), 0, 8'h00, 8'h00);
    wait_idle();
    drive(1, 8'h0A, 0, 8'h00, 8'h00);
    check("nl_150_cursor", {24'd0, cursor}, 32'd0);
    wait_idle();
    compare_writes(1'b0);

    // Out-of-range direct address
    drive(0, 8'h00, 1, 8'hA0, 8'h55);
    repeat (5) @(posedge clk);
    check("err_busy", {31'd0, busy}, 32'd0);
    compare_writes(1'b0);

    // Clear screen, with a direct request raised while it runs
    drive(1, 8'h0C, 0, 8'h00, 8'h00);
    repeat (10) @(posedge clk);
    drive(0, 8'h00, 1, 8'h05, 8'h77);
    check("clear_cursor", {24'd0, cursor}, 32'd0);
    wait_idle();
    compare_writes(1'b0);

    // Reset during the address strobe
    drive(1, 8'h0A, 0, 8'h00, 8'h00);
    drive(1, 8'h4D, 0, 8'h00, 8'h00);
    n = 0;
    while (!write_addr && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("stb_seen", {31'd0, write_addr}, 32'd1);
    @(posedge clk);
    do_reset();
    compare_writes(1'b1);
    drive(1, 8'h51, 1, 8'h50, 8'h31);
    wait_idle();
    compare_writes(1'b0);

    // Reset in the middle of a clear
    drive(1, 8'h0C, 0, 8'h00, 8'h00);
    repeat (500) @(posedge clk);
    do_reset();
    compare_writes(1'b1);
    drive(1, 8'h52, 0, 8'h00, 8'h00);
    wait_idle();
    compare_writes(1'b0);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      nc = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      if (nc == 0 && nd == 0) nc = 1;
      ch = ($urandom_range(0, 3) == 0) ? 8'h0A : rand_printable();
      drive(nc, ch, nd, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    wait_idle();
    compare_writes(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
